// File: rtl/arch_pkg.sv
// Shared architectural definitions for the forwarding unit: register index
// width, the history-entry record and the zero-register match helper.
package arch_pkg;
  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     we;
    logic     load;
  } hist_t;

  // Register 0 is hardwired, so it never produces a hazard.
  function automatic logic src_hit(hist_t e, reg_idx_t src, logic use_src);
    return use_src && (src != ZERO_REG) && e.valid && e.we && (e.dest == src);
  endfunction
endpackage

// File: rtl/forward_control_if.sv
// Decode-side bundle for forward_control. stall_count exists only when
// FWD_STALL_CNT_EN is defined.
interface forward_control_if;
  import arch_pkg::*;

  logic     dec_valid;
  reg_idx_t dec_src_a;
  reg_idx_t dec_src_b;
  logic     dec_use_a;
  logic     dec_use_b;
  reg_idx_t dec_dest;
  logic     dec_we;
  logic     dec_load;
  logic     flush;
  logic     one_a;
  logic     one_b;
  logic     two_a;
  logic     two_b;
  logic     stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  modport master (
    output dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
           dec_dest, dec_we, dec_load, flush,
    input  one_a, one_b, two_a, two_b, stall
`ifdef FWD_STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
           dec_dest, dec_we, dec_load, flush,
    output one_a, one_b, two_a, two_b, stall
`ifdef FWD_STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/fwd_history.sv
// Two-entry in-flight history (One = one ahead, Two = two ahead) with
// bubble insertion on stall and valid clearing on flush.
module fwd_history
  import arch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  stall,
  input  hist_t dec_ent,
  output hist_t one,
  output hist_t two
);
  hist_t one_q, one_d;
  hist_t two_q, two_d;

  always_comb begin
    one_d = one_q;
    two_d = two_q;
    if (flush) begin
      one_d.valid = 1'b0;
      two_d.valid = 1'b0;
    end else begin
      two_d = one_q;
      one_d = stall ? hist_t'('0) : dec_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      one_q <= '0;
      two_q <= '0;
    end else begin
      one_q <= one_d;
      two_q <= two_d;
    end
  end

  assign one = one_q;
  assign two = two_q;
endmodule

// File: rtl/forward_control.sv
// Operand-forwarding selects and load-use stall for a 2-deep pipeline.
// Optional stall counter enabled by macro FWD_STALL_CNT_EN.
module forward_control
  import arch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  forward_control_if.slave  fwd
);
  hist_t dec_ent, one, two;
  logic  live;
  logic  one_a, one_b, two_a, two_b, stall;

  always_comb begin
    dec_ent       = '0;
    dec_ent.valid = fwd.dec_valid;
    dec_ent.dest  = fwd.dec_dest;
    dec_ent.we    = fwd.dec_we;
    dec_ent.load  = fwd.dec_load;
  end

  fwd_history u_hist (
    .clk     (clk),
    .reset   (reset),
    .flush   (fwd.flush),
    .stall   (stall),
    .dec_ent (dec_ent),
    .one     (one),
    .two     (two)
  );

  // A load in One cannot forward yet; it stalls instead, and Two picks it up.
  always_comb begin
    live  = fwd.dec_valid && !fwd.flush;
    one_a = live && !one.load && src_hit(one, fwd.dec_src_a, fwd.dec_use_a);
    one_b = live && !one.load && src_hit(one, fwd.dec_src_b, fwd.dec_use_b);
    two_a = live && !one_a && src_hit(two, fwd.dec_src_a, fwd.dec_use_a);
    two_b = live && !one_b && src_hit(two, fwd.dec_src_b, fwd.dec_use_b);
    stall = live && one.load &&
            (src_hit(one, fwd.dec_src_a, fwd.dec_use_a) ||
             src_hit(one, fwd.dec_src_b, fwd.dec_use_b));
  end

  assign fwd.one_a = one_a;
  assign fwd.one_b = one_b;
  assign fwd.two_a = two_a;
  assign fwd.two_b = two_b;
  assign fwd.stall = stall;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign fwd.stall_count = stall_count_q;
`endif
endmodule

// File: doc/forward_control.md
FORWARD_CONTROL -- requirements
Module: forward_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port dec_valid, input, 1 bit: a decode-stage instruction is presented.
REQ-004 SHALL have ports dec_src_a and dec_src_b, input, 4 bits each: source register indices.
REQ-005 SHALL have ports dec_use_a and dec_use_b, input, 1 bit each: the corresponding source is actually read.
REQ-006 SHALL have port dec_dest, input, 4 bits: destination register index.
REQ-007 SHALL have port dec_we, input, 1 bit: the instruction writes dec_dest.
REQ-008 SHALL have port dec_load, input, 1 bit: the instruction is a memory load.
REQ-009 SHALL have port flush, input, 1 bit: discard all in-flight history.
REQ-010 SHALL have ports one_a, one_b, two_a, two_b, output, 1 bit each: forwarding selects driving the operand-forwarding multiplexers; 1 selects the forwarded stage value.
REQ-011 SHALL have port stall, output, 1 bit: decode must hold; a bubble is inserted.
REQ-012 SHALL have port stall_count, output, 16 bits, present only with FWD_STALL_CNT_EN.

Function
REQ-013 SHALL keep a two-entry history: stage One (one instruction ahead) and stage Two (two ahead), each holding valid, dest, we, load.
REQ-014 SHALL, each cycle without stall or flush, shift Two<=One and One<=decode fields, with One.valid=dec_valid.
REQ-015 SHALL, on a stall cycle, shift Two<=One and load One with a bubble (valid=0).
REQ-016 SHALL, on flush, clear both entries' valid bits next cycle; flush overrides stall and shift.
REQ-017 SHALL drive one_a=1 when dec_valid, dec_use_a, One.valid, One.we, !One.load, One.dest==dec_src_a, and dec_src_a!=0; one_b likewise for B.
REQ-018 SHALL drive two_a=1 when dec_valid, dec_use_a, Two.valid, Two.we, Two.dest==dec_src_a, dec_src_a!=0, and one_a=0; two_b likewise for B.
REQ-019 SHALL never assert one_x and two_x together for the same operand; stage One has priority.
REQ-020 SHALL assert stall for one cycle when dec_valid, One.valid, One.load, One.we, One.dest!=0, and One.dest matches a used source.
REQ-021 SHALL force all selects and stall to 0 while flush=1.
REQ-022 SHALL compute selects and stall combinationally from the registered history and current decode inputs, with zero-cycle latency.
REQ-023 SHALL never forward or stall on register 0.

Reset
REQ-024 SHALL clear both history valid bits on reset and drive all selects and stall to 0 in the cycle after reset is sampled, including when reset arrives mid-stall.
REQ-025 SHALL set stall_count to 0 on reset.

Configuration
REQ-026 SHALL, with macro FWD_STALL_CNT_EN defined, increment stall_count on every cycle where stall=1, saturating at 16'hFFFF.
REQ-027 SHALL, without FWD_STALL_CNT_EN, omit the stall_count port and its counter, with behaviour otherwise identical.

Structure
REQ-028 SHALL place the register-index width (4), the history-entry record typedef, and the zero-register constant in shared package arch_pkg.
REQ-029 SHALL implement the history as sub-module fwd_history (the two-entry shift register with bubble and flush); compare logic stays in forward_control.

Verification
REQ-030 ALU back-to-back: instruction 1 writes r3; next instruction reads src_a=r3 -> one_a=1, others 0, stall=0.
REQ-031 Distance two: r5 written, one unrelated instruction, then a read of src_b=r5 -> two_b=1, one_b=0.
REQ-032 Both stages write r2; the next instruction reads r2 on A -> one_a=1, two_a=0.
REQ-033 Load-use: load writes r4; next instruction reads r4 -> stall=1 for exactly one cycle; next cycle two_a=1, stall=0; stall_count=1 with the macro defined.
REQ-034 r0 hazards: writer with dest r0, reader with src r0 -> all selects 0, stall 0.
REQ-035 Flush and reset: flush asserted during a load-use stall -> stall=0 that cycle and no forwarding next cycle; reset mid-stall -> all outputs 0, stall_count=0.
